// File: rtl/key_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and registered edge strobes.
// The clean level only moves after the synchronised input has differed from it for STABLE_CYCLES edges.
module key_debounce_bit #(
  parameter int unsigned STABLE_CYCLES = 20000,
  parameter logic        IDLE          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any agreement with the clean level restarts the count, so bounces never accumulate.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      level_q <= IDLE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces a group of WIDTH switch/button inputs and flags any accepted change on the group.
// All outputs come from flops inside key_debounce_bit; changed is only an OR of registered strobes.
module key_debounce #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      STABLE_CYCLES = 20000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL    = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             changed
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << 20)) begin : g_bad_stable_cycles
    $error("key_debounce: STABLE_CYCLES must be in 2..2^20");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    key_debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .IDLE          (IDLE_LEVEL[i])
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (raw_in[i]),
      .level_out (level_out[i]),
      .rise_out  (rise_out[i]),
      .fall_out  (fall_out[i])
    );
  end

  assign changed = |(rise_out | fall_out);

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with STABLE_CYCLES=4, WIDTH=4; one idle-low and one idle-high instance.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw_lo, raw_hi;
  logic [3:0] lvl_lo, rise_lo, fall_lo;
  logic [3:0] lvl_hi, rise_hi, fall_hi;
  logic       chg_lo, chg_hi;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_debounce #(.WIDTH(4), .STABLE_CYCLES(4), .IDLE_LEVEL(4'b0000)) dut_lo (
    .clk(clk), .rst(rst), .raw_in(raw_lo),
    .level_out(lvl_lo), .rise_out(rise_lo), .fall_out(fall_lo), .changed(chg_lo)
  );

  key_debounce #(.WIDTH(4), .STABLE_CYCLES(4), .IDLE_LEVEL(4'b1111)) dut_hi (
    .clk(clk), .rst(rst), .raw_in(raw_hi),
    .level_out(lvl_hi), .rise_out(rise_hi), .fall_out(fall_hi), .changed(chg_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Full low-instance snapshot plus a "no activity" check on the idle-high instance.
  task automatic chk_lo(input string tag, input logic [3:0] lvl, input logic [3:0] rise,
                        input logic [3:0] fall, input logic chg);
    chk({tag, ".level"}, lvl_lo, lvl);
    chk({tag, ".rise"}, rise_lo, rise);
    chk({tag, ".fall"}, fall_lo, fall);
    chk({tag, ".changed"}, {3'b000, chg_lo}, {3'b000, chg});
    chk({tag, ".hi_changed"}, {3'b000, chg_hi}, 4'b0000);
  endtask

  initial begin
    rst    = 1'b0;
    raw_lo = 4'b1111;
    raw_hi = 4'b1111;

    // Reset held with inputs high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_lo("reset_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      chk("reset_hold.hi_level", lvl_hi, 4'b1111);
    end

    // Release: accepted on the 6th edge after release
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_lo("release_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick(); chk_lo("release_accept", 4'b1111, 4'b1111, 4'b0000, 1'b1);
    tick(); chk_lo("release_after", 4'b1111, 4'b0000, 4'b0000, 1'b0);

    raw_lo = 4'b0000;
    for (int i = 1; i <= 5; i++) tick();
    tick(); chk_lo("all_fall", 4'b0000, 4'b0000, 4'b1111, 1'b1);
    tick(); chk_lo("all_fall_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Clean step on bit 0
    raw_lo = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_lo("step0_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick(); chk_lo("step0_rise", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    tick(); chk_lo("step0_rise_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    raw_lo = 4'b0000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_lo("step0_fwait", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end
    tick(); chk_lo("step0_fall", 4'b0000, 4'b0000, 4'b0001, 1'b1);
    tick(); chk_lo("step0_fall_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Glitch: bit 1 high for 3 cycles only
    raw_lo = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_lo("glitch_hi", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    raw_lo = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_lo("glitch_lo", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end

    // Bounce 1,0,1,0 then steady 1
    for (int i = 0; i < 4; i++) begin
      raw_lo = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
      chk_lo("bounce", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    raw_lo = 4'b0010;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_lo("bounce_steady", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick(); chk_lo("bounce_rise", 4'b0010, 4'b0010, 4'b0000, 1'b1);
    tick(); chk_lo("bounce_rise_after", 4'b0010, 4'b0000, 4'b0000, 1'b0);
    raw_lo = 4'b0000;
    for (int i = 1; i <= 5; i++) tick();
    tick(); chk_lo("bounce_fall", 4'b0000, 4'b0000, 4'b0010, 1'b1);
    tick();

    // Simultaneous changes
    raw_lo = 4'b1010;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_lo("simul_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick(); chk_lo("simul_rise", 4'b1010, 4'b1010, 4'b0000, 1'b1);
    tick(); chk_lo("simul_rise_after", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    raw_lo = 4'b0101;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_lo("swap_wait", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    end
    tick(); chk_lo("swap_edge", 4'b0101, 4'b0101, 4'b1010, 1'b1);
    tick(); chk_lo("swap_after", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    raw_lo = 4'b0000;
    for (int i = 1; i <= 5; i++) tick();
    tick(); chk_lo("swap_fall", 4'b0000, 4'b0000, 4'b0101, 1'b1);
    tick();

    // Reset mid-count on bit 2 at edge 4
    raw_lo = 4'b0100;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_lo("midrst_count", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    rst = 1'b0;
    tick(); chk_lo("midrst_edge", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_lo("midrst_restart", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick(); chk_lo("midrst_rise", 4'b0100, 4'b0100, 4'b0000, 1'b1);
    tick(); chk_lo("midrst_after", 4'b0100, 4'b0000, 4'b0000, 1'b0);

    // Idle-high instance: pull bit 3 low
    chk("hi_level_idle", lvl_hi, 4'b1111);
    raw_hi = 4'b0111;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("hi_wait.level", lvl_hi, 4'b1111);
      chk("hi_wait.fall", fall_hi, 4'b0000);
    end
    tick();
    chk("hi_fall.level", lvl_hi, 4'b0111);
    chk("hi_fall.fall", fall_hi, 4'b1000);
    chk("hi_fall.rise", rise_hi, 4'b0000);
    chk("hi_fall.changed", {3'b000, chg_hi}, 4'b0001);
    tick();
    chk("hi_after.fall", fall_hi, 4'b0000);
    chk("hi_after.changed", {3'b000, chg_hi}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-conditioning stage for board switches and buttons, one instance per input group.
- Synchronises each raw pad bit to clk and debounces it.
- Presents clean levels plus one-cycle rise/fall strobes to downstream combinational blocks, e.g. the select and data inputs of the 4-to-1 key-mux.
- Also raises a group "changed" strobe so downstream logic can latch a new selection.

Parameters:
- WIDTH, 8: number of independent input bits.
- STABLE_CYCLES, 20000: consecutive clk cycles the synchronised level must differ from the current clean level before it is accepted. Legal range is 2 to 2^20.
- IDLE_LEVEL, {WIDTH{1'b0}}: per-bit value loaded into the synchroniser and clean level at reset. Use 1 for active-low buttons.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset (rst==0 at a clk rising edge resets the block).
- raw_in  input  WIDTH  asynchronous pad inputs.
- level_out  output  WIDTH  debounced clean level.
- rise_out  output  WIDTH  one-cycle pulse when the matching level_out bit goes 0->1.
- fall_out  output  WIDTH  one-cycle pulse when the matching level_out bit goes 1->0.
- changed  output  1  OR-reduction of (rise_out | fall_out).

Behaviour:
- One clock domain and one edge; all state updates on clk rising edge; reset is synchronous only.
- Reset (rst==0):
  - sync1 and sync2 = IDLE_LEVEL.
  - level_out = IDLE_LEVEL.
  - All counters = 0.
  - rise_out, fall_out and changed = 0.
  - Reset applied mid-count discards the count; no strobe fires on the reset edge or on the first edge after release.
- Per bit i, fully independent:
  - Synchroniser: sync1 <= raw_in[i]; sync2 <= sync1. Only sync2 is used after this.
  - Counter width: CNT_W = $clog2(STABLE_CYCLES).
  - If sync2 == level: cnt <= 0.
  - If sync2 != level and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - If sync2 != level and cnt == STABLE_CYCLES-1: level <= sync2, cnt <= 0, and the strobe for the direction is registered high for exactly the next cycle.
  - Strobes are registered, so they are high in the same cycle level_out first shows the new value.
- Latency: a clean raw_in step that is sampled into sync1 at edge 1 updates level_out at edge STABLE_CYCLES+2. With STABLE_CYCLES=4 that is edge 6.
- Glitch rejection: any return of sync2 to level before the count completes clears cnt to 0. level_out is unchanged and no strobe fires.
- The counter never wraps; it saturates at the accept condition and clears.
- Simultaneous changes on several bits are accepted independently; multiple strobe bits may be high in the same cycle, and changed is high once.
- After a change, the bit cannot produce another strobe for at least STABLE_CYCLES cycles.
- No combinational path from raw_in to any output.

Decomposition:
- No shared package needed.
- Constants local to the module: CNT_W = $clog2(STABLE_CYCLES), plus an elaboration check that STABLE_CYCLES >= 2.
- One natural sub-module, key_debounce_bit: a 1-bit synchroniser, counter and edge strobes, parameterised by STABLE_CYCLES and IDLE.
- The top level instantiates WIDTH copies in a generate loop and ORs the strobes into changed.

Test Plan (STABLE_CYCLES=4, WIDTH=4, IDLE_LEVEL=4'b0000 unless stated):
- Reset: hold rst=0 for 3 cycles with raw_in=4'b1111 -> level_out=0000, rise_out=fall_out=0, changed=0 throughout. Release rst and keep raw_in=1111 -> level_out=1111 at the 6th edge after release, rise_out=1111 and changed=1 for exactly that one cycle.
- Clean step: raw_in[0] goes 0->1 just before edge 1 -> level_out[0]=1 after edge 6, rise_out[0]=1 for one cycle only, no strobe on other bits. Then 1->0 -> fall_out[0] pulses after 6 edges.
- Glitch: raw_in[1] high for 3 cycles, then low -> level_out[1] stays 0, no strobe. Bounce pattern 1,0,1,0 then steady 1 -> a single rise_out[1] exactly 6 edges after the start of the steady 1.
- Simultaneous: raw_in changes 0000->1010 in one cycle -> rise_out=1010 in one cycle, changed=1 once. Then 1010->0101 -> rise_out=0101 and fall_out=1010 in the same cycle.
- Reset mid-count: step raw_in[2] to 1, assert rst=0 at edge 4 for one cycle -> level_out[2]=0 with no strobe on the reset edge. Count restarts and level_out[2]=1 arrives 6 edges after release.
- IDLE_LEVEL=4'b1111 instance with raw_in held at 1111 through reset release -> no strobe ever. Pulling raw_in[3] low -> fall_out[3] pulses after 6 edges.
